// File: rtl/egg_timer_pkg.sv
// Shared constants for the egg timer: FSM state encoding, BCD digit width,
// seconds limit and parameter defaults.
package egg_timer_pkg;

    localparam int DIGIT_W        = 4;
    localparam int SEC_LIMIT      = 59;
    localparam int DEF_MAX_MIN    = 99;
    localparam int DEF_ALARM_SECS = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    function automatic logic [DIGIT_W-1:0] tens_of(input int value);
        return DIGIT_W'(value / 10);
    endfunction

    function automatic logic [DIGIT_W-1:0] ones_of(input int value);
        return DIGIT_W'(value % 10);
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS held as four BCD digits with clear, minute/second increment and
// one-second decrement with borrow. Controls are mutually prioritised below.
module bcd_mmss_counter
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc_min,
    input  logic               inc_sec,
    input  logic               dec,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               zero,
    output logic               one
);

    localparam logic [DIGIT_W-1:0] MAX_T  = tens_of(MAX_MIN);
    localparam logic [DIGIT_W-1:0] MAX_O  = ones_of(MAX_MIN);
    localparam logic [DIGIT_W-1:0] SEC_T  = tens_of(SEC_LIMIT);
    localparam logic [DIGIT_W-1:0] SEC_O  = ones_of(SEC_LIMIT);
    localparam logic [DIGIT_W-1:0] NINE   = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] D_ZERO = '0;
    localparam logic [DIGIT_W-1:0] D_ONE  = DIGIT_W'(1);

    logic [DIGIT_W-1:0] mt_next, mo_next, st_next, so_next;
    logic               min_zero;

    assign min_zero = (min_tens == D_ZERO) && (min_ones == D_ZERO);
    assign zero     = min_zero && (sec_tens == D_ZERO) && (sec_ones == D_ZERO);
    assign one      = min_zero && (sec_tens == D_ZERO) && (sec_ones == D_ONE);

    // NOTE: every next-state variable gets a default before the branches, so no latch is inferred.
    always_comb begin
        mt_next = min_tens;
        mo_next = min_ones;
        st_next = sec_tens;
        so_next = sec_ones;
        if (clr) begin
            mt_next = D_ZERO;
            mo_next = D_ZERO;
            st_next = D_ZERO;
            so_next = D_ZERO;
        end else if (dec) begin
            if (sec_tens == D_ZERO && sec_ones == D_ZERO) begin
                // Borrow a minute; 00:00 holds rather than wrapping.
                if (!min_zero) begin
                    st_next = SEC_T;
                    so_next = SEC_O;
                    if (min_ones == D_ZERO) begin
                        mo_next = NINE;
                        mt_next = min_tens - D_ONE;
                    end else begin
                        mo_next = min_ones - D_ONE;
                    end
                end
            end else if (sec_ones == D_ZERO) begin
                so_next = NINE;
                st_next = sec_tens - D_ONE;
            end else begin
                so_next = sec_ones - D_ONE;
            end
        end else if (inc_min) begin
            if (min_tens == MAX_T && min_ones == MAX_O) begin
                mt_next = D_ZERO;
                mo_next = D_ZERO;
            end else if (min_ones == NINE) begin
                mo_next = D_ZERO;
                mt_next = min_tens + D_ONE;
            end else begin
                mo_next = min_ones + D_ONE;
            end
        end else if (inc_sec) begin
            // Seconds wrap 59 -> 00 without touching minutes.
            if (sec_tens == SEC_T && sec_ones == SEC_O) begin
                st_next = D_ZERO;
                so_next = D_ZERO;
            end else if (sec_ones == NINE) begin
                so_next = D_ZERO;
                st_next = sec_tens + D_ONE;
            end else begin
                so_next = sec_ones + D_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_tens <= D_ZERO;
            min_ones <= D_ZERO;
            sec_tens <= D_ZERO;
            sec_ones <= D_ZERO;
        end else begin
            min_tens <= mt_next;
            min_ones <= mo_next;
            sec_tens <= st_next;
            sec_ones <= so_next;
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: IDLE/RUN/PAUSE/ALARM FSM driving a BCD MM:SS counter,
// the divider enable/clear and the alarm output. All outputs are registered.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN    = DEF_MAX_MIN,
    parameter int ALARM_SECS = DEF_ALARM_SECS
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               btn_start,
    input  logic               btn_stop,
    input  logic               btn_min,
    input  logic               btn_sec,
    output logic               div_enable,
    output logic               div_clr,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               alarm,
    output logic [1:0]         state
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

    logic [1:0] state_next;
    logic [7:0] alarm_cnt, alarm_cnt_next;
    logic       div_clr_next;
    logic       cnt_clr, cnt_inc_min, cnt_inc_sec, cnt_dec;
    logic       time_zero, time_one;

    bcd_mmss_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_counter (
        .clk      (clk_in),
        .rst_n    (reset),
        .clr      (cnt_clr),
        .inc_min  (cnt_inc_min),
        .inc_sec  (cnt_inc_sec),
        .dec      (cnt_dec),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (time_zero),
        .one      (time_one)
    );

    // Inputs with no effect in the current state do not mask lower-priority ones.
    always_comb begin
        state_next     = state;
        alarm_cnt_next = alarm_cnt;
        div_clr_next   = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc_min    = 1'b0;
        cnt_inc_sec    = 1'b0;
        cnt_dec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_stop) begin
                    cnt_clr = 1'b1;
                end else if (btn_start && !time_zero) begin
                    state_next   = ST_RUN;
                    div_clr_next = 1'b1;
                end else if (btn_min) begin
                    cnt_inc_min = 1'b1;
                end else if (btn_sec) begin
                    cnt_inc_sec = 1'b1;
                end
            end
            ST_RUN: begin
                // A tick still counts down in the cycle btn_stop pauses.
                cnt_dec = tick_1hz;
                if (btn_stop) begin
                    state_next = ST_PAUSE;
                end else if (tick_1hz && (time_one || time_zero)) begin
                    state_next     = ST_ALARM;
                    alarm_cnt_next = 8'd0;
                end
            end
            ST_PAUSE: begin
                if (btn_stop) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end else if (btn_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn_stop || btn_start) begin
                    state_next     = ST_IDLE;
                    alarm_cnt_next = 8'd0;
                    cnt_clr        = 1'b1;
                end else if (tick_1hz) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_next     = ST_IDLE;
                        alarm_cnt_next = 8'd0;
                        cnt_clr        = 1'b1;
                    end else begin
                        alarm_cnt_next = alarm_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            alarm_cnt  <= 8'd0;
            div_clr    <= 1'b0;
            div_enable <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_next;
            alarm_cnt  <= alarm_cnt_next;
            div_clr    <= div_clr_next;
            div_enable <= (state_next == ST_RUN) || (state_next == ST_ALARM);
            alarm      <= (state_next == ST_ALARM);
        end
    end

endmodule

// File: doc/egg_timer_ctrl.md
EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter MAX_MIN, default 99: highest settable minute value, 1..99.
REQ-002 Parameter ALARM_SECS, default 10: alarm duration in 1 Hz ticks, 1..255.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick_1hz  input  1  one-cycle pulse from the divider chain, synchronous to clk_in.
REQ-006 btn_start  input  1  debounced one-cycle pulse: start or resume.
REQ-007 btn_stop  input  1  debounced one-cycle pulse: pause, clear or silence.
REQ-008 btn_min  input  1  debounced one-cycle pulse: add one minute while setting.
REQ-009 btn_sec  input  1  debounced one-cycle pulse: add one second while setting.
REQ-010 div_enable  output  1  enable to the clock-divider chain.
REQ-011 div_clr  output  1  one-cycle pulse that zeroes the divider counters.
REQ-012 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits.
REQ-013 alarm  output  1  high while the alarm sounds.
REQ-014 state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Function
REQ-015 All outputs shall be registered; every response shall appear on the cycle after the triggering input.
REQ-016 Same-cycle priority shall be: btn_stop, then btn_start, then tick_1hz, then btn_min, then btn_sec.
REQ-017 IDLE: btn_min shall increment minutes, wrapping from MAX_MIN to 00; btn_sec shall increment seconds, wrapping from 59 to 00 with no carry into minutes.
REQ-018 IDLE: btn_start with a nonzero time shall enter RUN and pulse div_clr for one cycle; btn_start at 00:00 shall be ignored.
REQ-019 IDLE: btn_stop shall clear the time to 00:00.
REQ-020 RUN: div_enable shall be 1; each tick_1hz shall decrement MM:SS by one second in BCD, borrowing from minutes when seconds are 00 (for example 10:00 -> 09:59).
REQ-021 RUN: a tick at 00:01 shall set the time to 00:00 and enter ALARM in the same update.
REQ-022 RUN: btn_stop shall enter PAUSE; a tick in the same cycle shall still decrement the time.
REQ-023 RUN and PAUSE: btn_min and btn_sec shall be ignored.
REQ-024 PAUSE: div_enable shall be 0 and the time held; btn_start shall resume RUN without div_clr; btn_stop shall enter IDLE with the time cleared to 00:00.
REQ-025 ALARM: alarm and div_enable shall be 1; an 8-bit counter shall count ticks, and the block shall enter IDLE at 00:00 after ALARM_SECS ticks.
REQ-026 ALARM: btn_stop or btn_start shall enter IDLE immediately with alarm deasserted.
REQ-027 In IDLE, div_enable and alarm shall be 0.
REQ-028 BCD digits shall never hold codes above 9; sec_tens shall never exceed 5.

Reset
REQ-029 On reset low, the block shall asynchronously force state IDLE, all BCD digits 0, div_enable 0, div_clr 0, alarm 0 and the alarm counter 0.
REQ-030 Reset asserted mid-RUN or mid-ALARM shall abort with no residual pulse; operation shall resume on the first clock edge after reset is released.

Structure
REQ-031 A shared package, egg_timer_pkg, shall hold the state encoding, BCD digit width, the seconds limit 59, and default MAX_MIN and ALARM_SECS.
REQ-032 A single sub-module, bcd_mmss_counter, shall hold MM:SS with load-clear, increment-minute, increment-second and decrement-with-borrow controls plus a zero flag; the FSM stays in egg_timer_ctrl.

Verification
REQ-033 In IDLE, 3 btn_min and 75 btn_sec pulses -> display 03:15; sec_tens never exceeds 5.
REQ-034 Set 01:00, btn_start, then 2 ticks -> div_clr pulse one cycle after btn_start; display 00:59, then 00:58.
REQ-035 Set 00:02, btn_start, 2 ticks -> 00:00; state ALARM and alarm 1 on the cycle after the second tick; IDLE after 10 further ticks.
REQ-036 In RUN, btn_stop and tick in the same cycle at 00:30 -> PAUSE at 00:29 with div_enable 0; btn_start -> RUN with no div_clr.
REQ-037 btn_start at 00:00 -> stays IDLE; btn_stop during ALARM -> IDLE and alarm 0 on the next cycle.
REQ-038 Reset low mid-RUN at 05:00 -> all outputs immediately IDLE, 00:00 and 0, with no clock edge required.
